// File: rtl/io_bus_responder_if.sv
// io_bus_responder_if: core IO bus (address/ctrl/write data/strobe out, read data/hit back).
// The core drives through the master modport; the peripheral responder uses the slave modport.
interface io_bus_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [1:0]        ctrl;
    logic [DATA_W-1:0] wd;
    logic              we;
    logic [DATA_W-1:0] rd;
    logic              hit;

    modport master (output addr, ctrl, wd, we, input rd, hit);
    modport slave  (input addr, ctrl, wd, we, output rd, hit);
endinterface

// File: rtl/io_bus_responder.sv
// io_bus_responder: LED, switch, seven-segment and timer registers in a 4 KiB IO window, 1-cycle read latency.
// Optional IO_TIMER_IRQ_EN adds TCTRL.IE (bit3) and the level timer_irq output.
module io_bus_responder #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000,
    parameter int unsigned SW_W      = 24,
    parameter int unsigned LED_W     = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    io_bus_responder_if.slave    bus,
    input  logic [SW_W-1:0]      sw_in,
    output logic [LED_W-1:0]     led_out,
    output logic [31:0]          seg_out
`ifdef IO_TIMER_IRQ_EN
    ,
    output logic                 timer_irq
`endif
);
    localparam int unsigned WIN_BYTES = 4096;
    localparam logic [9:0]  IDX_LED   = 10'h000;
    localparam logic [9:0]  IDX_SW    = 10'h001;
    localparam logic [9:0]  IDX_SEG   = 10'h002;
    localparam logic [9:0]  IDX_TCNT  = 10'h003;
    localparam logic [9:0]  IDX_TCTRL = 10'h004;
    localparam logic [9:0]  IDX_TPSC  = 10'h005;
    localparam logic [9:0]  IDX_TCMP  = 10'h006;

    logic [ADDR_W-1:0] off;
    logic              in_win;
    logic [9:0]        idx;
    logic [3:0]        strb;
    logic [31:0]       wd;
    logic              wr;
    logic              wr_tcnt, wr_tctrl, wr_tpsc;

    logic [SW_W-1:0]   sw_s1, sw_s2;
    logic [31:0]       tcnt, tcmp;
    logic [15:0]       tpsc, pcnt;
    logic              en, auto_rl, ovf, ie;
    logic              tick, match, ovf_n;
    logic [31:0]       m_led, m_seg, m_tcnt, m_tpsc, m_tcmp;
    logic [31:0]       rdata;

    // Replace only the strobed byte lanes of a register.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    assign off    = bus.addr - ADDR_W'(BASE_ADDR);
    assign in_win = off < ADDR_W'(WIN_BYTES);
    assign idx    = off[11:2];
    assign wd     = 32'(bus.wd);

    // Misaligned half/word accesses produce no strobes, so they never write.
    always_comb begin
        strb = 4'b0000;
        unique case (bus.ctrl)
            2'b10:   strb = 4'b0001 << off[1:0];
            2'b01:   if (!off[0]) strb = off[1] ? 4'b1100 : 4'b0011;
            default: if (off[1:0] == 2'b00) strb = 4'b1111;
        endcase
    end

    assign wr       = bus.we & in_win & (|strb);
    assign wr_tcnt  = wr && (idx == IDX_TCNT);
    assign wr_tctrl = wr && (idx == IDX_TCTRL);
    assign wr_tpsc  = wr && (idx == IDX_TPSC);

    always_comb begin
        m_led  = merge(32'(led_out), wd, strb);
        m_seg  = merge(seg_out, wd, strb);
        m_tcnt = merge(tcnt, wd, strb);
        m_tpsc = merge({16'h0000, tpsc}, wd, strb);
        m_tcmp = merge(tcmp, wd, strb);
    end

    assign tick  = en && (pcnt == tpsc);
    assign match = (tcnt == tcmp);

    // Hardware set of OVF takes priority over a same-cycle write-1-to-clear.
    always_comb begin
        ovf_n = ovf;
        if (wr_tctrl && strb[0] && wd[2]) ovf_n = 1'b0;
        if (tick && match)                ovf_n = 1'b1;
    end

    always_comb begin
        rdata = '0;
        if (in_win) begin
            case (idx)
                IDX_LED:   rdata = 32'(led_out);
                IDX_SW:    rdata = 32'(sw_s2);
                IDX_SEG:   rdata = seg_out;
                IDX_TCNT:  rdata = tcnt;
                IDX_TCTRL: rdata = {28'h0, ie, ovf, auto_rl, en};
                IDX_TPSC:  rdata = {16'h0000, tpsc};
                IDX_TCMP:  rdata = tcmp;
                default:   rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd  <= '0;
            bus.hit <= 1'b0;
            sw_s1   <= '0;
            sw_s2   <= '0;
            led_out <= '0;
            seg_out <= '0;
            tcnt    <= '0;
            tcmp    <= '0;
            tpsc    <= '0;
            pcnt    <= '0;
            en      <= 1'b0;
            auto_rl <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            bus.rd  <= DATA_W'(rdata);
            bus.hit <= in_win;
            sw_s1   <= sw_in;
            sw_s2   <= sw_s1;
            if (wr && (idx == IDX_LED)) led_out <= m_led[LED_W-1:0];
            if (wr && (idx == IDX_SEG)) seg_out <= m_seg;
            if (wr && (idx == IDX_TCMP)) tcmp <= m_tcmp;
            if (wr_tpsc) tpsc <= m_tpsc[15:0];
            if (wr_tctrl && strb[0]) begin
                en      <= wd[0];
                auto_rl <= wd[1];
            end
            ovf <= ovf_n;

            if (wr_tpsc || wr_tctrl || !en || tick) pcnt <= '0;
            else                                    pcnt <= pcnt + 16'd1;

            // A bus write to TCNT overrides the timer's own update.
            if (wr_tcnt)              tcnt <= m_tcnt;
            else if (tick && !match)  tcnt <= tcnt + 32'd1;
            else if (tick && auto_rl) tcnt <= '0;
        end
    end

`ifdef IO_TIMER_IRQ_EN
    logic ie_n;
    assign ie_n = (wr_tctrl && strb[0]) ? wd[3] : ie;

    always_ff @(posedge clk) begin
        if (rst) begin
            ie        <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            ie        <= ie_n;
            timer_irq <= ovf_n & ie_n;
        end
    end
`else
    assign ie = 1'b0;
`endif
endmodule

// File: tb/tb_io_bus_responder.sv
// tb_io_bus_responder: directed plus random bus traffic, behavioural register-map model and scoreboard.
// The monitor pops one expected response per clock and compares outputs mid-cycle.
module tb_io_bus_responder;
    localparam logic [31:0] BASE = 32'hFFFF_F000;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] sw_in;
    logic [23:0] led_out;
    logic [31:0] seg_out;
`ifdef IO_TIMER_IRQ_EN
    logic        timer_irq;
`endif

    always #5 clk = ~clk;

    io_bus_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    io_bus_responder #(
        .ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'hFFFF_F000), .SW_W(24), .LED_W(24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .sw_in(sw_in),
        .led_out(led_out),
        .seg_out(seg_out)
`ifdef IO_TIMER_IRQ_EN
        ,
        .timer_irq(timer_irq)
`endif
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        hit;
        logic [23:0] led;
        logic [31:0] seg;
        logic        irq;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference state of the register map, all held as plain 32-bit values.
    logic [31:0] m_led, m_seg, m_tcnt, m_tcmp, m_tpsc, m_pcnt;
    logic        m_en, m_auto, m_ovf, m_ie;
    logic [23:0] sw_hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [9:0] idx);
        case (idx)
            10'd0:   return m_led;
            10'd1:   return {8'h00, sw_hist[0]};
            10'd2:   return m_seg;
            10'd3:   return m_tcnt;
            10'd4:   return {28'h0, m_ie, m_ovf, m_auto, m_en};
            10'd5:   return m_tpsc;
            10'd6:   return m_tcmp;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge for the given bus inputs and queue the expected outputs.
    task automatic model_step(input logic r, input logic we, input logic [31:0] addr,
                              input logic [1:0] ctrl, input logic [31:0] wd, input logic [23:0] sw);
        exp_t        e;
        logic [31:0] o, mask, nt;
        logic [9:0]  idx;
        logic        inwin, aligned, tick, at_cmp, clr, no;
        logic [31:0] np;
        int unsigned sz, lane;
        e = '0;
        if (r) begin
            m_led = 0; m_seg = 0; m_tcnt = 0; m_tcmp = 0; m_tpsc = 0; m_pcnt = 0;
            m_en = 0; m_auto = 0; m_ovf = 0; m_ie = 0;
            sw_hist = '{24'h0, 24'h0};
            q.push_back(e);
            return;
        end
        o     = addr - BASE;
        inwin = o < 32'h1000;
        idx   = o[11:2];
        e.rd  = inwin ? mread(idx) : 32'h0;
        e.hit = inwin;

        sz      = (ctrl == 2'b10) ? 1 : (ctrl == 2'b01) ? 2 : 4;
        lane    = 32'(addr[1:0]);
        aligned = (lane % sz) == 0;
        mask    = 32'h0;
        for (int unsigned b = 0; b < sz; b++) mask |= 32'hFF << (8 * ((lane + b) % 4));

        tick   = m_en && (m_pcnt == m_tpsc);
        at_cmp = (m_tcnt == m_tcmp);
        nt     = m_tcnt;
        if (tick) begin
            if (!at_cmp)     nt = m_tcnt + 1;
            else if (m_auto) nt = 0;
        end
        np  = (m_en && !tick) ? m_pcnt + 1 : 32'h0;
        clr = 1'b0;

        if (we && inwin && aligned) begin
            case (idx)
                10'd0: m_led  = ((m_led & ~mask) | (wd & mask)) & 32'h00FF_FFFF;
                10'd2: m_seg  = (m_seg & ~mask) | (wd & mask);
                10'd3: nt     = (m_tcnt & ~mask) | (wd & mask);
                10'd4: begin
                    if (mask[0]) begin
                        m_en   = wd[0];
                        m_auto = wd[1];
                        clr    = wd[2];
`ifdef IO_TIMER_IRQ_EN
                        m_ie   = wd[3];
`endif
                    end
                    np = 0;
                end
                10'd5: begin
                    m_tpsc = ((m_tpsc & ~mask) | (wd & mask)) & 32'h0000_FFFF;
                    np     = 0;
                end
                10'd6: m_tcmp = (m_tcmp & ~mask) | (wd & mask);
                default: ;
            endcase
        end
        no = m_ovf;
        if (clr)              no = 1'b0;
        if (tick && at_cmp)   no = 1'b1;
        m_tcnt = nt;
        m_ovf  = no;
        m_pcnt = np;
        sw_hist.push_back(sw);
        void'(sw_hist.pop_front());

        e.led = m_led[23:0];
        e.seg = m_seg;
        e.irq = m_ovf & m_ie;
        q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic we, input logic [31:0] addr,
                       input logic [1:0] ctrl, input logic [31:0] wd);
        rst      = r;
        bus.we   = we;
        bus.addr = addr;
        bus.ctrl = ctrl;
        bus.wd   = wd;
        model_step(r, we, addr, ctrl, wd, sw_in);
        @(posedge clk);
        #1;
    endtask

    task automatic wr32(input logic [31:0] off, input logic [31:0] v);
        cyc(1'b0, 1'b1, BASE + off, 2'b00, v);
    endtask

    task automatic rd32(input logic [31:0] off);
        cyc(1'b0, 1'b0, BASE + off, 2'b00, 32'h0);
    endtask

    // Scoreboard monitor: one expected response per clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("bus_rd", bus.rd, e.rd);
                chk("bus_hit", 32'(bus.hit), 32'(e.hit));
                chk("led_out", 32'(led_out), 32'(e.led));
                chk("seg_out", seg_out, e.seg);
`ifdef IO_TIMER_IRQ_EN
                chk("timer_irq", 32'(timer_irq), 32'(e.irq));
`endif
            end
        end
    end

    initial begin
        logic [31:0] off, a, w;
        logic [1:0]  c;
        sw_in = 24'h0;

        cyc(1'b1, 1'b0, BASE, 2'b00, 32'h0);
        cyc(1'b1, 1'b0, BASE, 2'b00, 32'h0);
        rd32(32'h00); rd32(32'h08); rd32(32'h10);

        // Byte lanes
        wr32(32'h00, 32'h00AA_BBCC);
        cyc(1'b0, 1'b1, BASE + 32'h01, 2'b10, 32'h0000_1100);
        chk("led_byte_merge", 32'(led_out), 32'h00AA_11CC);
        rd32(32'h00);
        wr32(32'h08, 32'h1234_5678);
        cyc(1'b0, 1'b1, BASE + 32'h09, 2'b01, 32'hFFFF_FFFF);
        chk("seg_misaligned_half", seg_out, 32'h1234_5678);
        cyc(1'b0, 1'b1, BASE + 32'h0A, 2'b01, 32'hBEEF_0000);
        rd32(32'h08);

        // Switch synchroniser
        sw_in = 24'h12_3456;
        repeat (5) rd32(32'h04);

        // Timer auto-reload
        wr32(32'h14, 32'd3);
        wr32(32'h18, 32'd5);
        wr32(32'h10, 32'h3);
        for (int i = 0; i < 40; i++) rd32((i % 2 == 0) ? 32'h10 : 32'h0C);

        // Timer without auto-reload, then collisions with TPSC=0
        wr32(32'h10, 32'h4);
        wr32(32'h0C, 32'h0);
        wr32(32'h10, 32'h1);
        for (int i = 0; i < 36; i++) rd32(32'h0C);
        wr32(32'h14, 32'd0);
        rd32(32'h0C); rd32(32'h10);
        wr32(32'h0C, 32'd7);
        rd32(32'h0C);
        wr32(32'h0C, 32'd5);
        wr32(32'h10, 32'h5);
        rd32(32'h10); rd32(32'h0C);
        wr32(32'h10, 32'h4);
        rd32(32'h10);

        // Out of window
        cyc(1'b0, 1'b0, BASE + 32'h1000, 2'b00, 32'h0);
        cyc(1'b0, 1'b1, BASE + 32'h1000, 2'b00, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b1, BASE - 32'h4, 2'b00, 32'hDEAD_BEEF);
        rd32(32'h00); rd32(32'h08); rd32(32'h18);

        // Reset with a read pending
        rd32(32'h18);
        cyc(1'b1, 1'b0, BASE + 32'h18, 2'b00, 32'h0);
        rd32(32'h18);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) sw_in = 24'($urandom);
            off = 32'($urandom_range(0, 8) * 4 + $urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = BASE + 32'h1000 + off;
                1:       a = BASE - 32'h20 + off;
                default: a = BASE + off;
            endcase
            c = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), a, c, w);
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
